// File: rtl/ms11_mem.sv
// ms11_mem -- Unibus slave memory backed by internal block RAM.
//
// Answers DATI/DATIP/DATO/DATOB cycles from any bus master with SSYN, read
// data and parity status. The ARM programs an enable and a block window, and
// reads cycle counters, through a small register file:
//   0 ro 32'h4D532001 identification
//   1 rw [31] enable, [29:24] hiblk, [21:16] loblk (4KB blocks, a[17:12])
//   2 ro {datocnt, daticnt}; any write clears both
//   3 parity flags when MS11_PARITY_EN is defined, else 32'hDEADBEEF
//   4-7 read 32'hDEADBEEF
//
// Optional feature macro: MS11_PARITY_EN (per-byte parity-error flags).
//
// Ports:
//   CLOCK, RESET          100MHz clock, synchronous active-high reset
//   armwrite/armwaddr/armwdata  ARM register write strobe, select, data
//   armraddr/armrdata     ARM register read select, combinational read data
//   turbo                 shortens the access delay to 2 clocks
//   a_in_h/c_in_h/d_in_h  Unibus address, control, data
//   del_msyn_in_h         synchronized MSYN (A/C/D stable when high)
//   init_in_h             Unibus INIT
//   d_out_h               read data onto the bus, 0 when not driving
//   ssyn_out_h            slave sync
//   pb_out_h, pa_out_h    parity bits B (error indication) and A (always 0)
module ms11_mem #(
  parameter int NWORDS_LOG2 = 15,
  parameter int ACCESS_CLKS = 20
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        turbo,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        del_msyn_in_h,
  input  logic        init_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h,
  output logic        pb_out_h,
  output logic        pa_out_h
);

  localparam int NWORDS = 2 ** NWORDS_LOG2;
  localparam int CW     = (ACCESS_CLKS > 2) ? $clog2(ACCESS_CLKS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, WAITNEG} state_t;

  state_t                 state, state_nxt;
  logic                   enable;
  logic [5:0]             loblk, hiblk;
  logic [15:0]            daticnt, datocnt;
  logic [31:0]            reg3_rdata;

  // Address decode: block window, I/O page excluded, and RAM depth limit.
  logic [5:0]             bus_blk;
  logic [16:0]            word_off;
  logic                   in_depth, match;

  assign bus_blk  = a_in_h[17:12];
  assign word_off = a_in_h[17:1] - {loblk, 11'b0};
  assign in_depth = {1'b0, word_off} < (18'd1 << NWORDS_LOG2);
  assign match    = enable && (bus_blk >= loblk) && (bus_blk <= hiblk) &&
                    (bus_blk < 6'd62) && in_depth;

  // Cycle parameters captured when the slave accepts MSYN.
  logic [NWORDS_LOG2-1:0] lat_idx;
  logic [1:0]             lat_c;
  logic                   lat_a0;
  logic [15:0]            lat_d;
  logic [CW-1:0]          cnt, cnt_limit;

  assign cnt_limit = turbo ? CW'(1) : CW'(ACCESS_CLKS - 1);

  logic bus_clr, start, op_fire, release_bus, is_write;
  assign bus_clr  = RESET | init_in_h;
  assign is_write = lat_c[1];
  assign pa_out_h = 1'b0;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_nxt   = state;
    start       = 1'b0;
    op_fire     = 1'b0;
    release_bus = 1'b0;
    unique case (state)
      IDLE:
        if (del_msyn_in_h && match) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      ACCESS:
        if (cnt >= cnt_limit) begin
          op_fire   = 1'b1;
          // A master that already dropped MSYN gets a single-cycle SSYN.
          state_nxt = del_msyn_in_h ? RESP : WAITNEG;
        end
      RESP:
        state_nxt = WAITNEG;
      WAITNEG:
        if (!del_msyn_in_h) begin
          release_bus = 1'b1;
          state_nxt   = IDLE;
        end
      default:
        state_nxt = IDLE;
    endcase
    if (bus_clr) begin
      state_nxt   = IDLE;
      start       = 1'b0;
      op_fire     = 1'b0;
      release_bus = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    // NOTE: clocked state uses non-blocking assignment so all registers update together.
    if (bus_clr) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge CLOCK) begin
    if (start) begin
      lat_idx <= word_off[NWORDS_LOG2-1:0];
      lat_c   <= c_in_h;
      lat_a0  <= a_in_h[0];
      lat_d   <= d_in_h;
      cnt     <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Byte lanes: DATO writes both; DATOB picks the lane by a[0].
  logic [15:0] ram [NWORDS];
  logic        wr_lo, wr_hi;

  assign wr_lo = op_fire && is_write && !(lat_c[0] &&  lat_a0);
  assign wr_hi = op_fire && is_write && !(lat_c[0] && !lat_a0);

  always_ff @(posedge CLOCK) begin
    // NOTE: the RAM has no reset so it maps onto block RAM and keeps contents across RESET.
    if (wr_lo) ram[lat_idx][7:0]  <= lat_d[7:0];
    if (wr_hi) ram[lat_idx][15:8] <= lat_d[15:8];
  end

  always_ff @(posedge CLOCK) begin
    if (bus_clr || release_bus) begin
      ssyn_out_h <= 1'b0;
      d_out_h    <= '0;
    end else if (op_fire) begin
      ssyn_out_h <= 1'b1;
      if (!is_write) d_out_h <= ram[lat_idx];
    end
  end

`ifdef MS11_PARITY_EN
  logic [1:0]             pflags [NWORDS];
  logic [NWORDS_LOG2-1:0] flag_sel, arm_idx;
  logic                   arm_flag_we;

  assign arm_idx     = armwdata[NWORDS_LOG2:1];
  assign arm_flag_we = armwrite && (armwaddr == 3'd3);

  // Bus writes clear the written bytes' flags; an ARM set on the same word wins.
  always_ff @(posedge CLOCK) begin
    if (wr_lo) pflags[lat_idx][0] <= 1'b0;
    if (wr_hi) pflags[lat_idx][1] <= 1'b0;
    if (arm_flag_we) begin
      pflags[arm_idx] <= armwdata[1:0];
      flag_sel        <= arm_idx;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (bus_clr || release_bus) pb_out_h <= 1'b0;
    else if (op_fire && !is_write) pb_out_h <= |pflags[lat_idx];
  end

  assign reg3_rdata = {30'd0, pflags[flag_sel]};
`else
  assign pb_out_h   = 1'b0;
  assign reg3_rdata = 32'hDEADBEEF;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable  <= 1'b0;
      loblk   <= '0;
      hiblk   <= '0;
      daticnt <= '0;
      datocnt <= '0;
    end else begin
      if (op_fire && !is_write) daticnt <= daticnt + 16'd1;
      if (op_fire &&  is_write) datocnt <= datocnt + 16'd1;
      // A clear from the ARM takes priority over a same-cycle increment.
      if (armwrite) begin
        case (armwaddr)
          3'd1: begin
            enable <= armwdata[31];
            hiblk  <= armwdata[29:24];
            loblk  <= armwdata[21:16];
          end
          3'd2: begin
            daticnt <= '0;
            datocnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    armrdata = 32'hDEADBEEF;
    case (armraddr)
      3'd0: armrdata = 32'h4D532001;
      3'd1: armrdata = {enable, 1'b0, hiblk, 2'b00, loblk, 16'h0000};
      3'd2: armrdata = {datocnt, daticnt};
      3'd3: armrdata = reg3_rdata;
      default: ;
    endcase
  end

  logic unused_armwdata;
  assign unused_armwdata = ^armwdata;

endmodule

// File: tb/tb_ms11_mem.sv
// Self-checking bench for ms11_mem: directed Unibus/ARM steps followed by a
// randomized cycle mix, checked against a word-indexed memory model.
module tb_ms11_mem;

  localparam int ACCESS_CLKS = 20;
  localparam int NWL2        = 15;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        armwrite = 1'b0;
  logic [2:0]  armraddr = '0;
  logic [2:0]  armwaddr = '0;
  logic [31:0] armwdata = '0;
  logic [31:0] armrdata;
  logic        turbo = 1'b0;
  logic [17:0] a_in_h = '0;
  logic [1:0]  c_in_h = '0;
  logic [15:0] d_in_h = '0;
  logic        del_msyn_in_h = 1'b0;
  logic        init_in_h = 1'b0;
  logic [15:0] d_out_h;
  logic        ssyn_out_h, pb_out_h, pa_out_h;

  ms11_mem dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata), .turbo(turbo),
    .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
    .del_msyn_in_h(del_msyn_in_h), .init_in_h(init_in_h),
    .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h),
    .pb_out_h(pb_out_h), .pa_out_h(pa_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: RAM words and per-byte flags keyed by RAM word index.
  logic [15:0] mdl_mem  [int];
  logic [1:0]  mdl_flag [int];
  int          mdl_flag_sel = 0;
  bit          mdl_en = 1'b0;
  int          mdl_lo = 0, mdl_hi = 0;
  int          mdl_dati = 0, mdl_dato = 0;
  logic [15:0] last_rd;
  logic        last_pb;
  int          wq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic int mdl_index(input logic [17:0] addr);
    return int'(addr[17:1]) - mdl_lo * 2048;
  endfunction

  function automatic bit mdl_match(input logic [17:0] addr);
    int blk, off;
    blk = int'(addr) / 4096;
    off = mdl_index(addr);
    return mdl_en && blk >= mdl_lo && blk <= mdl_hi && blk < 62 &&
           off >= 0 && off < (1 << NWL2);
  endfunction

  task automatic arm_wr(input logic [2:0] addr, input logic [31:0] data);
    armwaddr = addr;
    armwdata = data;
    armwrite = 1'b1;
    tick();
    armwrite = 1'b0;
    if (addr == 3'd1) begin
      mdl_en = data[31];
      mdl_hi = int'(data[29:24]);
      mdl_lo = int'(data[21:16]);
    end else if (addr == 3'd2) begin
      mdl_dati = 0;
      mdl_dato = 0;
    end else if (addr == 3'd3) begin
      mdl_flag_sel = int'(data[NWL2:1]);
      mdl_flag[mdl_flag_sel] = data[1:0];
    end
  endtask

  task automatic arm_rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    armraddr = addr;
    #1;
    check(tag, armrdata, exp);
  endtask

  function automatic logic [31:0] mdl_counts();
    logic [31:0] v;
    v = {mdl_dato[15:0], mdl_dati[15:0]};
    return v;
  endfunction

  // One full master cycle: MSYN up, wait for SSYN, hold, drop, see release.
  task automatic bus_cycle(input logic [17:0] addr, input logic [1:0] ctl,
                           input logic [15:0] data, input string tag);
    int lat, idx;
    bit seen;
    logic [15:0] w, exp_d;
    logic [1:0] f;
    logic exp_pb;
    idx = mdl_index(addr);
    a_in_h = addr;
    c_in_h = ctl;
    d_in_h = data;
    del_msyn_in_h = 1'b1;
    tick();
    // The slave latched A/C/D on that edge; changes now must be ignored.
    a_in_h = 18'($urandom);
    c_in_h = 2'($urandom);
    d_in_h = 16'($urandom);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      lat++;
      if (ssyn_out_h) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " ssyn"}, 32'(seen), 32'd1);
    check({tag, " latency"}, lat, turbo ? 2 : ACCESS_CLKS);
    exp_d = '0;
    exp_pb = 1'b0;
    if (ctl[1] == 1'b0) begin
      exp_d = mdl_mem.exists(idx) ? mdl_mem[idx] : 16'h0000;
`ifdef MS11_PARITY_EN
      exp_pb = mdl_flag.exists(idx) ? |mdl_flag[idx] : 1'b0;
`endif
      last_rd = d_out_h;
      last_pb = pb_out_h;
      check({tag, " rdata"}, d_out_h, exp_d);
      check({tag, " pb"}, pb_out_h, exp_pb);
      mdl_dati++;
    end else begin
      w = mdl_mem.exists(idx) ? mdl_mem[idx] : 16'h0000;
      f = mdl_flag.exists(idx) ? mdl_flag[idx] : 2'b00;
      if (ctl == 2'd2) begin
        w = data;
        f = 2'b00;
      end else if (addr[0]) begin
        w[15:8] = data[15:8];
        f[1] = 1'b0;
      end else begin
        w[7:0] = data[7:0];
        f[0] = 1'b0;
      end
      mdl_mem[idx] = w;
      mdl_flag[idx] = f;
      mdl_dato++;
    end
    tick();
    check({tag, " ssyn hold"}, ssyn_out_h, 1'b1);
    if (ctl[1] == 1'b0) check({tag, " rdata hold"}, d_out_h, exp_d);
    del_msyn_in_h = 1'b0;
    tick();
    check({tag, " release"}, {d_out_h, ssyn_out_h, pb_out_h}, 18'h0);
  endtask

  // A cycle the slave must not answer.
  task automatic no_match(input logic [17:0] addr, input int cycles, input string tag);
    int highs;
    a_in_h = addr;
    c_in_h = 2'd0;
    d_in_h = '0;
    del_msyn_in_h = 1'b1;
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ssyn_out_h !== 1'b0) highs++;
    end
    check({tag, " no ssyn"}, highs, 0);
    del_msyn_in_h = 1'b0;
    tick();
  endtask

  initial begin
    int highs, r, idx, blk;
    logic [17:0] addr;
    logic [15:0] held;

    repeat (3) tick();
    RESET = 1'b0;
    tick();
    check("reset outputs", {d_out_h, ssyn_out_h, pb_out_h, pa_out_h}, 19'h0);
    arm_rd(3'd0, 32'h4D532001, "reg0 id");
    arm_rd(3'd1, 32'h0, "reg1 reset");
    arm_rd(3'd2, 32'h0, "reg2 reset");
    arm_rd(3'd7, 32'hDEADBEEF, "reg7");
`ifndef MS11_PARITY_EN
    arm_rd(3'd3, 32'hDEADBEEF, "reg3 absent");
`endif

    // Basic word write/read, window lo=hi=0.
    arm_wr(3'd1, 32'h8000_0000);
    arm_rd(3'd1, 32'h8000_0000, "reg1 readback");
    bus_cycle(18'o001000, 2'd2, 16'o123456, "dato 1000");
    bus_cycle(18'o001000, 2'd0, 16'h0, "dati 1000");
    check("dati 1000 const", last_rd, 16'o123456);
    arm_rd(3'd2, 32'h0001_0001, "counts 1/1");

    // Byte writes.
    bus_cycle(18'o002000, 2'd2, 16'o177777, "dato 2000");
    bus_cycle(18'o002001, 2'd3, 16'o000400, "datob 2001");
    bus_cycle(18'o002000, 2'd0, 16'h0, "dati 2000a");
    check("datob hi const", last_rd, 16'o000777);
    bus_cycle(18'o002000, 2'd3, 16'o000012, "datob 2000");
    bus_cycle(18'o002000, 2'd1, 16'h0, "datip 2000");
    check("datob lo const", last_rd, 16'o000412);

    // Decode boundaries.
    arm_wr(3'd1, 32'h0000_0000);
    no_match(18'o001000, 2000, "disabled");
    arm_wr(3'd1, 32'h8101_0000);
    no_match(18'o001000, 2000, "below window");
    arm_wr(3'd1, 32'hBF00_0000);
    no_match(18'o760000, 2000, "io page");
    no_match(18'o200000, 50, "past depth");
    bus_cycle(18'o177776, 2'd2, 16'o052525, "dato last word");
    bus_cycle(18'o177776, 2'd0, 16'h0, "dati last word");

    // INIT during ACCESS of a DATO abandons the write.
    arm_wr(3'd1, 32'h8000_0000);
    a_in_h = 18'o001000;
    c_in_h = 2'd2;
    d_in_h = 16'o055555;
    del_msyn_in_h = 1'b1;
    tick();
    repeat (5) tick();
    init_in_h = 1'b1;
    del_msyn_in_h = 1'b0;
    highs = 0;
    repeat (2) begin
      tick();
      if (ssyn_out_h !== 1'b0) highs++;
    end
    init_in_h = 1'b0;
    repeat (40) begin
      tick();
      if (ssyn_out_h !== 1'b0) highs++;
    end
    check("init abort ssyn", highs, 0);
    bus_cycle(18'o001000, 2'd0, 16'h0, "dati after init");

    // MSYN dropped mid-ACCESS: op completes, SSYN for exactly one cycle.
    a_in_h = 18'o002000;
    c_in_h = 2'd0;
    d_in_h = '0;
    del_msyn_in_h = 1'b1;
    tick();
    repeat (5) tick();
    del_msyn_in_h = 1'b0;
    highs = 0;
    held = '0;
    repeat (40) begin
      tick();
      if (ssyn_out_h !== 1'b0) begin
        highs++;
        held = d_out_h;
      end
    end
    mdl_dati++;
    check("early drop ssyn cycles", highs, 1);
    check("early drop rdata", held, mdl_mem[mdl_index(18'o002000)]);

    // Turbo timing.
    turbo = 1'b1;
    bus_cycle(18'o001000, 2'd0, 16'h0, "turbo dati");
    bus_cycle(18'o001002, 2'd2, 16'o007070, "turbo dato");
    turbo = 1'b0;
    arm_rd(3'd2, mdl_counts(), "counts directed");
    arm_wr(3'd2, 32'h0);
    arm_rd(3'd2, 32'h0, "counts cleared");

`ifdef MS11_PARITY_EN
    bus_cycle(18'o003000, 2'd2, 16'h1234, "par dato");
    arm_wr(3'd3, (32'h300 << 1) | 32'h1);
    arm_rd(3'd3, {30'd0, mdl_flag[mdl_flag_sel]}, "par reg3 set");
    bus_cycle(18'o003000, 2'd0, 16'h0, "par dati flagged");
    check("par pb const", last_pb, 1'b1);
    bus_cycle(18'o003000, 2'd3, 16'h0055, "par datob");
    bus_cycle(18'o003000, 2'd0, 16'h0, "par dati cleared");
    check("par pb clear const", last_pb, 1'b0);
    arm_rd(3'd3, {30'd0, mdl_flag[mdl_flag_sel]}, "par reg3 cleared");
`endif

    // Randomized mix inside window blocks 2..9, with stray out-of-window cycles.
    arm_wr(3'd1, {1'b1, 1'b0, 6'd9, 2'b00, 6'd2, 16'h0});
    for (int n = 0; n < 40; n++) begin
      turbo = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        blk = int'($urandom_range(0, 55));
        blk = (blk < 2) ? blk : blk + 8;
        addr = 18'(blk * 4096 + int'($urandom_range(0, 4095)));
        check("rand decode model", 32'(mdl_match(addr)), 32'd0);
        no_match(addr, 30, "rand outside");
      end else if (wq.size() == 0 || r < 5) begin
        addr = 18'(int'($urandom_range(2 * 4096, 10 * 4096 - 1)) & ~1);
        idx = mdl_index(addr);
        if (mdl_mem.exists(idx) && $urandom_range(0, 1) == 1)
          bus_cycle(addr | 18'($urandom_range(0, 1)), 2'd3, 16'($urandom), "rand datob");
        else
          bus_cycle(addr, 2'd2, 16'($urandom), "rand dato");
        wq.push_back(int'(addr));
      end else begin
        addr = 18'(wq[$urandom_range(0, wq.size() - 1)]);
        bus_cycle(addr, 2'($urandom_range(0, 1)), 16'($urandom), "rand dati");
      end
    end
    turbo = 1'b0;
    arm_rd(3'd2, mdl_counts(), "counts random");

    // RESET clears registers but not RAM.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    mdl_en = 1'b0;
    mdl_lo = 0;
    mdl_hi = 0;
    mdl_dati = 0;
    mdl_dato = 0;
    tick();
    arm_rd(3'd1, 32'h0, "reg1 after reset");
    arm_rd(3'd2, 32'h0, "reg2 after reset");
    arm_wr(3'd1, 32'h8000_0000);
    bus_cycle(18'o001000, 2'd0, 16'h0, "ram kept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
